// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU instruction/data memory port: memory
// geometry, response-owner encoding and the address legality check.
package cpu_mem_pkg;

    localparam int MEM_DEPTH = 3000;
    localparam int BE_W      = 4;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_F    = 2'd1,
        RSP_D    = 2'd2
    } rsp_owner_t;

    // A byte address is rejected when it is not word aligned or when its
    // full 30-bit word index lies beyond the end of the memory.
    function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] depth);
        logic [31:0] idx;
        idx = {2'b00, addr[31:2]};
        return (addr[1:0] != 2'b00) || (idx >= depth);
    endfunction

endpackage

// File: rtl/mem_rsp_router.sv
// Tracks which requester owns the access issued last cycle and steers the
// one-cycle-late RAM read data (or an error / write acknowledge) back to it.
module mem_rsp_router
    import cpu_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        grant_f,
    input  logic        grant_d,
    input  logic        grant_bad,
    input  logic        grant_we,
    input  logic [31:0] mem_rdata,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    output logic        f_err,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err
);

    rsp_owner_t owner_r;
    logic       bad_r;
    logic       we_r;
    logic [31:0] rsp_data_s;

    // Owner FSM: next state is simply whoever was granted this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r <= RSP_NONE;
            bad_r   <= 1'b0;
            we_r    <= 1'b0;
        end else begin
            case ({grant_f, grant_d})
                2'b10:   owner_r <= RSP_F;
                2'b01:   owner_r <= RSP_D;
                default: owner_r <= RSP_NONE;
            endcase
            bad_r <= grant_bad;
            we_r  <= grant_we;
        end
    end

    // Write acks and rejected accesses return zero data, good reads the RAM word.
    always_comb begin
        if (bad_r || we_r) begin
            rsp_data_s = 32'h0000_0000;
        end else begin
            rsp_data_s = mem_rdata;
        end
    end

    // Route the response to the owner; an in-flight response is dropped under reset.
    always_comb begin
        f_rvalid = 1'b0;
        f_rdata  = 32'h0000_0000;
        f_err    = 1'b0;
        d_rvalid = 1'b0;
        d_rdata  = 32'h0000_0000;
        d_err    = 1'b0;
        if (rst) begin
            f_rvalid = 1'b0;
            d_rvalid = 1'b0;
        end else begin
            case (owner_r)
                RSP_F: begin
                    f_rvalid = 1'b1;
                    f_err    = bad_r;
                    f_rdata  = rsp_data_s;
                end
                RSP_D: begin
                    d_rvalid = 1'b1;
                    d_err    = bad_r;
                    d_rdata  = rsp_data_s;
                end
                default: begin
                    f_rvalid = 1'b0;
                    d_rvalid = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single BRAM port between CPU fetch and load/store. Data wins
// contention except when fetch has already been denied MAX_WAIT cycles in
// a row. Misaligned or out-of-range accesses are granted but never reach
// the RAM; they come back as error responses.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH    = MEM_DEPTH,
    parameter int MAX_WAIT = 4,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    output logic              f_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [BE_W-1:0]   d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic              d_err,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic [BE_W-1:0]   mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_SAT = WW'(MAX_WAIT);

    logic [WW-1:0] wait_cnt_r;
    logic          f_bad_s;
    logic          d_bad_s;
    logic          starve_s;
    logic          f_gnt_s;
    logic          d_gnt_s;
    logic          grant_bad_s;
    logic          grant_we_s;

    assign f_bad_s  = addr_bad(f_addr, 32'(DEPTH));
    assign d_bad_s  = addr_bad(d_addr, 32'(DEPTH));
    assign starve_s = (wait_cnt_r == WAIT_SAT);

    // Fixed data priority with an anti-starvation override for fetch.
    always_comb begin
        f_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (rst) begin
            f_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end else if (f_req && d_req) begin
            f_gnt_s = starve_s;
            d_gnt_s = !starve_s;
        end else begin
            f_gnt_s = f_req;
            d_gnt_s = d_req;
        end
    end

    assign f_gnt = f_gnt_s;
    assign d_gnt = d_gnt_s;

    // Drive the RAM port from the winner; rejected accesses leave it idle.
    always_comb begin
        mem_en      = 1'b0;
        mem_we      = {BE_W{1'b0}};
        mem_addr    = {AW{1'b0}};
        mem_wdata   = 32'h0000_0000;
        grant_bad_s = 1'b0;
        grant_we_s  = 1'b0;
        if (f_gnt_s) begin
            mem_en      = !f_bad_s;
            mem_addr    = f_addr[AW+1:2];
            grant_bad_s = f_bad_s;
        end else if (d_gnt_s) begin
            mem_en      = !d_bad_s;
            mem_addr    = d_addr[AW+1:2];
            mem_wdata   = d_wdata;
            grant_bad_s = d_bad_s;
            grant_we_s  = d_we;
            if (d_we && !d_bad_s) begin
                mem_we = d_be;
            end else begin
                mem_we = {BE_W{1'b0}};
            end
        end else begin
            mem_en = 1'b0;
        end
    end

    // Count consecutive denied fetch cycles, saturating at MAX_WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= {WW{1'b0}};
        end else if (f_req && !f_gnt_s) begin
            if (!starve_s) begin
                wait_cnt_r <= wait_cnt_r + {{(WW-1){1'b0}}, 1'b1};
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end else begin
            wait_cnt_r <= {WW{1'b0}};
        end
    end

    mem_rsp_router u_rsp (
        .clk       (clk),
        .rst       (rst),
        .grant_f   (f_gnt_s),
        .grant_d   (d_gnt_s),
        .grant_bad (grant_bad_s),
        .grant_we  (grant_we_s),
        .mem_rdata (mem_rdata),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .f_err     (f_err),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a BRAM model on the memory side, directed
// scenarios with literal expectations, then randomized traffic checked
// every cycle against a behavioural model with its own golden memory.
module tb_mem_port_arbiter;

    localparam int          DEPTH    = 3000;
    localparam int          MAX_WAIT = 4;
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_L  = 32'd3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt, f_rvalid, f_err;
    logic [31:0] f_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_err = 0;
    int n_chk = 0;
    bit last_f_gnt = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_rdata(f_rdata), .f_err(f_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 5)         return 32'h9300_0201;
        else if (i == 8)    return 32'h1122_3344;
        else if (i == 2999) return 32'hCAFE_F00D;
        else                return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    function automatic bit model_bad(input logic [31:0] a);
        return ((a % 32'd4) != 32'd0) || ((a / 32'd4) >= DEPTH_L);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // BRAM model: port inputs captured mid-cycle, applied on the rising edge.
    initial begin
        logic [31:0] ram [0:(1<<AW)-1];
        logic          c_en;
        logic [3:0]    c_we;
        logic [AW-1:0] c_addr;
        logic [31:0]   c_wdata;
        for (int i = 0; i < (1 << AW); i++) ram[i] = init_word(i);
        mem_rdata = 32'h0000_0000;
        forever begin
            @(negedge clk);
            c_en = mem_en; c_we = mem_we; c_addr = mem_addr; c_wdata = mem_wdata;
            @(posedge clk);
            if (c_en) begin
                mem_rdata = ram[c_addr];
                for (int b = 0; b < 4; b++)
                    if (c_we[b]) ram[c_addr][8*b +: 8] = c_wdata[8*b +: 8];
            end
        end
    end

    // Reference model and per-cycle comparison of every DUT output.
    initial begin
        logic [31:0] golden [0:DEPTH-1];
        int          wcnt;
        int          pend_owner;
        bit          pend_err;
        logic [31:0] pend_data;
        bit egf, egd, fb, db, een;
        logic [3:0]  ewe;
        int          idx;
        for (int i = 0; i < DEPTH; i++) golden[i] = init_word(i);
        wcnt = 0; pend_owner = 0; pend_err = 1'b0; pend_data = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_f_gnt",    32'(f_gnt), 32'd0);
                check("rst_d_gnt",    32'(d_gnt), 32'd0);
                check("rst_mem_en",   32'(mem_en), 32'd0);
                check("rst_mem_we",   32'(mem_we), 32'd0);
                check("rst_f_rvalid", 32'(f_rvalid), 32'd0);
                check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
                check("rst_f_err",    32'(f_err), 32'd0);
                check("rst_d_err",    32'(d_err), 32'd0);
                check("rst_f_rdata",  f_rdata, 32'd0);
                check("rst_d_rdata",  d_rdata, 32'd0);
                wcnt = 0; pend_owner = 0;
                last_f_gnt = 1'b0;
            end else begin
                check("m_f_rvalid", 32'(f_rvalid), 32'(pend_owner == 1));
                check("m_d_rvalid", 32'(d_rvalid), 32'(pend_owner == 2));
                check("m_f_err",    32'(f_err),    32'(pend_owner == 1 && pend_err));
                check("m_d_err",    32'(d_err),    32'(pend_owner == 2 && pend_err));
                check("m_f_rdata",  f_rdata, (pend_owner == 1) ? pend_data : 32'd0);
                check("m_d_rdata",  d_rdata, (pend_owner == 2) ? pend_data : 32'd0);

                egf = f_req && (!d_req || wcnt == MAX_WAIT);
                egd = d_req && !egf;
                fb  = model_bad(f_addr);
                db  = model_bad(d_addr);
                check("m_f_gnt", 32'(f_gnt), 32'(egf));
                check("m_d_gnt", 32'(d_gnt), 32'(egd));
                een = (egf && !fb) || (egd && !db);
                ewe = (egd && !db && d_we) ? d_be : 4'b0000;
                check("m_mem_en", 32'(mem_en), 32'(een));
                check("m_mem_we", 32'(mem_we), 32'(ewe));
                if (een) check("m_mem_addr", 32'(mem_addr), (egf ? f_addr : d_addr) / 32'd4);
                if (ewe != 4'b0000) check("m_mem_wdata", mem_wdata, d_wdata);

                pend_owner = 0;
                if (egf) begin
                    pend_owner = 1;
                    pend_err   = fb;
                    pend_data  = fb ? 32'd0 : golden[int'(f_addr / 32'd4)];
                end else if (egd) begin
                    pend_owner = 2;
                    pend_err   = db;
                    pend_data  = 32'd0;
                    if (!db) begin
                        idx = int'(d_addr / 32'd4);
                        if (!d_we) pend_data = golden[idx];
                        else for (int b = 0; b < 4; b++)
                            if (d_be[b]) golden[idx][8*b +: 8] = d_wdata[8*b +: 8];
                    end
                end
                if (f_req && !egf) wcnt = (wcnt < MAX_WAIT) ? wcnt + 1 : MAX_WAIT;
                else               wcnt = 0;
                last_f_gnt = egf;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return (32'($urandom_range(0, DEPTH - 1)) * 32'd4) | 32'($urandom_range(1, 3));
            1:       return 32'd12000;
            2:       return 32'd11996;
            3:       return 32'hFFFF_FFFC;
            4:       return 32'd11997;
            default: return 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
        endcase
    endfunction

    // Stimulus: directed scenarios with literal expectations, then random traffic.
    initial begin
        rst = 1'b1; idle();
        f_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
        #1;
        f_req = 1'b1; f_addr = 32'h14;
        @(negedge clk);
        check("reset_no_gnt", 32'(f_gnt), 32'd0);
        tick(); tick();

        // single fetch of word 5
        rst = 1'b0; f_req = 1'b1; f_addr = 32'h14;
        @(negedge clk);
        check("t1_f_gnt", 32'(f_gnt), 32'd1);
        check("t1_mem_addr", 32'(mem_addr), 32'd5);
        check("t1_mem_en", 32'(mem_en), 32'd1);
        tick(); idle();
        @(negedge clk);
        check("t1_f_rvalid", 32'(f_rvalid), 32'd1);
        check("t1_f_rdata", f_rdata, 32'h9300_0201);
        check("t1_f_err", 32'(f_err), 32'd0);

        // partial write then read back word 8
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hAABB_CCDD; d_be = 4'b0011;
        @(negedge clk);
        check("t2_mem_we", 32'(mem_we), 32'h3);
        tick(); d_we = 1'b0;
        @(negedge clk);
        check("t2_ack_rvalid", 32'(d_rvalid), 32'd1);
        check("t2_ack_rdata", d_rdata, 32'd0);
        tick(); idle();
        @(negedge clk);
        check("t2_rd_data", d_rdata, 32'h1122_CCDD);
        tick();

        // sustained contention
        f_req = 1'b1; f_addr = 32'h14; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("t3_f_gnt", 32'(f_gnt), 32'(c == 4 || c == 9));
            check("t3_d_gnt", 32'(d_gnt), 32'(!(c == 4 || c == 9)));
            tick();
        end
        idle(); tick();

        // rejected accesses and last valid word
        d_req = 1'b1; d_addr = 32'd12000;
        @(negedge clk);
        check("t4_bad_mem_en", 32'(mem_en), 32'd0);
        tick(); d_req = 1'b0; f_req = 1'b1; f_addr = 32'h2;
        @(negedge clk);
        check("t4_d_err", 32'(d_err), 32'd1);
        check("t4_d_rdata", d_rdata, 32'd0);
        check("t4_f_gnt", 32'(f_gnt), 32'd1);
        tick(); f_req = 1'b0; d_req = 1'b1; d_addr = 32'd11996;
        @(negedge clk);
        check("t4_f_err", 32'(f_err), 32'd1);
        check("t4_f_rvalid", 32'(f_rvalid), 32'd1);
        tick(); idle();
        @(negedge clk);
        check("t4_last_word", d_rdata, 32'hCAFE_F00D);
        check("t4_last_err", 32'(d_err), 32'd0);
        tick();

        // reset while a fetch response is in flight
        f_req = 1'b1; f_addr = 32'h14;
        @(negedge clk);
        check("t5_f_gnt", 32'(f_gnt), 32'd1);
        tick(); rst = 1'b1; f_req = 1'b0;
        @(negedge clk);
        check("t5_rst_rvalid", 32'(f_rvalid), 32'd0);
        tick(); rst = 1'b0;
        @(negedge clk);
        check("t5_post_rvalid", 32'(f_rvalid), 32'd0);
        tick(); f_req = 1'b1;
        @(negedge clk);
        check("t5_again_gnt", 32'(f_gnt), 32'd1);
        tick(); f_req = 1'b0;
        @(negedge clk);
        check("t5_again_data", f_rdata, 32'h9300_0201);
        tick();

        // alternating single requests, back to back
        f_req = 1'b1; f_addr = 32'h14;
        tick(); f_req = 1'b0; d_req = 1'b1; d_addr = 32'h20;
        @(negedge clk);
        check("t6_c1_f_rdata", f_rdata, 32'h9300_0201);
        tick(); d_req = 1'b0; f_req = 1'b1;
        @(negedge clk);
        check("t6_c2_d_rdata", d_rdata, 32'h1122_CCDD);
        check("t6_c2_f_rvalid", 32'(f_rvalid), 32'd0);
        tick(); f_req = 1'b0; d_req = 1'b1;
        @(negedge clk);
        check("t6_c3_f_rvalid", 32'(f_rvalid), 32'd1);
        tick(); idle();
        @(negedge clk);
        check("t6_c4_d_rvalid", 32'(d_rvalid), 32'd1);
        tick();

        // randomized traffic obeying the hold-until-grant protocol
        for (int c = 0; c < 3000; c++) begin
            if (!(f_req && !last_f_gnt) || $urandom_range(0, 15) == 0) begin
                f_req  = ($urandom_range(0, 2) != 0);
                f_addr = rand_addr();
            end
            if (!(d_req && !d_gnt) || $urandom_range(0, 15) == 0) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = ($urandom_range(0, 1) != 0);
                d_addr  = rand_addr();
                d_wdata = $urandom();
                d_be    = 4'($urandom_range(0, 15));
            end
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; idle();
        tick(); tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
